// File: rtl/dice_pkg.sv
// Shared die codes, FSM state encoding, register map and die-maximum lookup for the dice scheduler.
package dice_pkg;

  localparam logic [2:0] DieD4      = 3'd0;
  localparam logic [2:0] DieD6      = 3'd1;
  localparam logic [2:0] DieD8      = 3'd2;
  localparam logic [2:0] DieD10     = 3'd3;
  localparam logic [2:0] DieD12     = 3'd4;
  localparam logic [2:0] DieD20     = 3'd5;
  localparam logic [2:0] DieD100    = 3'd6;
  localparam logic [2:0] DieInvalid = 3'd7;

  localparam logic [7:0] AddrStatus  = 8'h00;
  localparam logic [7:0] AddrResult  = 8'h01;
  localparam logic [7:0] AddrCmd     = 8'h02;
  localparam logic [7:0] AddrRollCnt = 8'h03;

  typedef enum logic [1:0] {
    StIdle,
    StRollBtn,
    StRollI2c,
    StHold
  } state_e;

  // Highest face of each die as two BCD digits; d100 spans 00..99.
  function automatic logic [7:0] die_max(input logic [2:0] code);
    logic [7:0] n;
    case (code)
      DieD4:   n = 8'h04;
      DieD6:   n = 8'h06;
      DieD8:   n = 8'h08;
      DieD10:  n = 8'h10;
      DieD12:  n = 8'h12;
      DieD20:  n = 8'h20;
      DieD100: n = 8'h99;
      default: n = 8'h00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dice_bcd_engine.sv
// Two-digit BCD roll counter: loads the die maximum, then decrements with wrap back to the maximum.
module dice_bcd_engine
  import dice_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] max,
  output logic [3:0] digit10,
  output logic [3:0] digit1
);

  logic [7:0] value_q, value_d;
  logic       at_wrap;

  // d100 counts 99..00, every other die counts N..1.
  assign at_wrap = (max == 8'h99) ? (value_q == 8'h00) : (value_q == 8'h01);

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = max;
    end else if (dec) begin
      if (at_wrap) begin
        value_d = max;
      end else if (value_q[3:0] == 4'd0) begin
        value_d = {value_q[7:4] - 4'd1, 4'd9};
      end else begin
        value_d = {value_q[7:4], value_q[3:0] - 4'd1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= 8'h00;
    end else begin
      value_q <= value_d;
    end
  end

  assign digit10 = value_q[7:4];
  assign digit1  = value_q[3:0];

endmodule

// File: rtl/dice_roll_sched.sv
// Arbitrates the BCD roll engine between die buttons and I2C, sequences rolls, exposes registers.
// Optional DICE_SCHED_ROLLCNT_EN adds a saturating completed-roll counter at address 0x03.
module dice_roll_sched
  import dice_pkg::*;
#(
  parameter int unsigned I2C_MIN_CYCLES = 16,
  parameter int unsigned SEED_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] btn_req,
  input  logic       i2c_wen,
  input  logic [7:0] i2c_addr,
  input  logic [7:0] i2c_wdata,
  input  logic       i2c_rdata_used,
  output logic [7:0] i2c_rdata,
  output logic [3:0] digit10,
  output logic [3:0] digit1,
  output logic       busy,
  output logic       result_valid,
  output logic       roll_done
);

  localparam int unsigned RemW = $clog2(I2C_MIN_CYCLES + (2 ** SEED_W) + 1);

  state_e            state_q, state_d;
  logic [2:0]        die_q, die_d;
  logic              owner_q, owner_d;
  logic [RemW-1:0]   rem_q, rem_d;
  logic [SEED_W-1:0] seed_q;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic              reject_q, reject_d;
  logic              badcode_q, badcode_d;
  logic              reject_set, badcode_set, sticky_clr;
  logic              cmd_wr;
  logic              eng_load, eng_dec;
  logic [2:0]        btn_code;
  logic [7:0]        rollcnt;
  logic              unused_wdata;

  assign unused_wdata = ^i2c_wdata[7:3];
  assign cmd_wr       = i2c_wen && (i2c_addr == AddrCmd);
  assign sticky_clr   = i2c_rdata_used && (i2c_addr == AddrStatus);

  // Lowest set request bit selects the die.
  always_comb begin
    btn_code = DieD4;
    for (int i = 6; i >= 0; i--) begin
      if (btn_req[i]) btn_code = 3'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    die_d       = die_q;
    owner_d     = owner_q;
    rem_d       = rem_q;
    done_d      = 1'b0;
    valid_d     = valid_q;
    eng_load    = 1'b0;
    eng_dec     = 1'b0;
    reject_set  = 1'b0;
    badcode_set = 1'b0;
    unique case (state_q)
      StIdle, StHold: begin
        if (btn_req != 7'd0) begin
          state_d    = StRollBtn;
          die_d      = btn_code;
          owner_d    = 1'b0;
          valid_d    = 1'b0;
          eng_load   = 1'b1;
          reject_set = cmd_wr;
        end else if (cmd_wr) begin
          if (i2c_wdata[2:0] == DieInvalid) begin
            badcode_set = 1'b1;
          end else begin
            state_d  = StRollI2c;
            die_d    = i2c_wdata[2:0];
            owner_d  = 1'b1;
            valid_d  = 1'b0;
            eng_load = 1'b1;
            rem_d    = RemW'(I2C_MIN_CYCLES) + RemW'(seed_q);
          end
        end
      end
      StRollBtn: begin
        reject_set = cmd_wr;
        if (btn_req != 7'd0) begin
          eng_dec = 1'b1;
        end else begin
          state_d = StHold;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      StRollI2c: begin
        reject_set = cmd_wr;
        if (rem_q != '0) begin
          eng_dec = 1'b1;
          rem_d   = rem_q - RemW'(1);
        end
        if (rem_q <= RemW'(1)) begin
          state_d = StHold;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A set event in the same cycle beats a read-clear.
  assign reject_d  = reject_set  ? 1'b1 : (sticky_clr ? 1'b0 : reject_q);
  assign badcode_d = badcode_set ? 1'b1 : (sticky_clr ? 1'b0 : badcode_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      die_q     <= DieD4;
      owner_q   <= 1'b0;
      rem_q     <= '0;
      seed_q    <= '0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      reject_q  <= 1'b0;
      badcode_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      die_q     <= die_d;
      owner_q   <= owner_d;
      rem_q     <= rem_d;
      seed_q    <= seed_q + SEED_W'(1);
      done_q    <= done_d;
      valid_q   <= valid_d;
      reject_q  <= reject_d;
      badcode_q <= badcode_d;
    end
  end

`ifdef DICE_SCHED_ROLLCNT_EN
  logic [7:0] rollcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rollcnt_q <= 8'd0;
    end else if (done_d && (rollcnt_q != 8'hff)) begin
      rollcnt_q <= rollcnt_q + 8'd1;
    end
  end

  assign rollcnt = rollcnt_q;
`else
  assign rollcnt = 8'd0;
`endif

  // Maximum follows die_d so the entry-cycle load sees the newly selected die.
  dice_bcd_engine u_engine (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (eng_load),
    .dec     (eng_dec),
    .max     (die_max(die_d)),
    .digit10 (digit10),
    .digit1  (digit1)
  );

  assign busy         = (state_q == StRollBtn) || (state_q == StRollI2c);
  assign result_valid = valid_q;
  assign roll_done    = done_q;

  always_comb begin
    i2c_rdata = 8'h00;
    case (i2c_addr)
      AddrStatus:  i2c_rdata = {die_q, badcode_q, reject_q, owner_q, valid_q, busy};
      AddrResult:  i2c_rdata = {digit10, digit1};
      AddrCmd:     i2c_rdata = {5'd0, die_q};
      AddrRollCnt: i2c_rdata = rollcnt;
      default:     i2c_rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_dice_roll_sched.sv
// Directed self-checking bench for dice_roll_sched with hand-computed expectations.
module tb_dice_roll_sched;

  logic       clk;
  logic       rst_n;
  logic [6:0] btn_req;
  logic       i2c_wen;
  logic [7:0] i2c_addr;
  logic [7:0] i2c_wdata;
  logic       i2c_rdata_used;
  logic [7:0] i2c_rdata;
  logic [3:0] digit10;
  logic [3:0] digit1;
  logic       busy;
  logic       result_valid;
  logic       roll_done;

  int tests_run;
  int tests_failed;

  dice_roll_sched dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_req        (btn_req),
    .i2c_wen        (i2c_wen),
    .i2c_addr       (i2c_addr),
    .i2c_wdata      (i2c_wdata),
    .i2c_rdata_used (i2c_rdata_used),
    .i2c_rdata      (i2c_rdata),
    .digit10        (digit10),
    .digit1         (digit1),
    .busy           (busy),
    .result_valid   (result_valid),
    .roll_done      (roll_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    i2c_addr = addr;
    #1;
    check(tag, i2c_rdata, exp);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    btn_req        = 7'd0;
    i2c_wen        = 1'b0;
    i2c_addr       = 8'h00;
    i2c_wdata      = 8'h00;
    i2c_rdata_used = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic cmd_write(input logic [7:0] addr, input logic [7:0] data);
    i2c_wen   = 1'b1;
    i2c_addr  = addr;
    i2c_wdata = data;
    step();
    i2c_wen = 1'b0;
  endtask

  int n;

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Reset state
    do_reset();
    check("rst_digits", {digit10, digit1}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_valid", {7'd0, result_valid}, 8'h00);
    check("rst_done", {7'd0, roll_done}, 8'h00);
    read_chk("rst_status", 8'h00, 8'h00);

    // d6 held 11 cycles: load 6, then 5,4,3,2,1,6,5,4,3,2
    btn_req = 7'b0000010;
    repeat (11) step();
    btn_req = 7'd0;
    check("d6_busy", {7'd0, busy}, 8'h01);
    step();
    check("d6_done", {7'd0, roll_done}, 8'h01);
    check("d6_valid", {7'd0, result_valid}, 8'h01);
    check("d6_digits", {digit10, digit1}, 8'h02);
    check("d6_busy_end", {7'd0, busy}, 8'h00);
    step();
    check("d6_done_pulse", {7'd0, roll_done}, 8'h00);
    read_chk("d6_status", 8'h00, 8'h22);

    // d100 held 101 cycles: load 99, 100 decrements wrap 00 -> 99
    btn_req = 7'b1000000;
    step();
    check("d100_valid_clr", {7'd0, result_valid}, 8'h00);
    repeat (100) step();
    btn_req = 7'd0;
    step();
    check("d100_digits", {digit10, digit1}, 8'h99);
    read_chk("d100_status", 8'h00, 8'hc2);

    // I2C d20 with seed 4: 20 busy cycles, 20 -> ... -> 1 -> 20
    do_reset();
    repeat (4) step();
    cmd_write(8'h02, 8'h05);
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check("i2c_busy_cycles", 8'(n), 8'd20);
    check("i2c_done", {7'd0, roll_done}, 8'h01);
    check("i2c_digits", {digit10, digit1}, 8'h20);
    read_chk("i2c_status", 8'h00, 8'ha6);
    read_chk("i2c_cmd_rd", 8'h02, 8'h05);
    read_chk("i2c_result_rd", 8'h01, 8'h20);

    // Button and CMD write together: button wins, reject set
    btn_req = 7'b0000001;
    cmd_write(8'h02, 8'h01);
    check("coll_busy", {7'd0, busy}, 8'h01);
    read_chk("coll_status", 8'h00, 8'h09);
    i2c_rdata_used = 1'b1;
    step();
    i2c_rdata_used = 1'b0;
    read_chk("coll_clear", 8'h00, 8'h01);
    btn_req = 7'd0;
    step();
    check("coll_digits", {digit10, digit1}, 8'h03);

    // Invalid die code: no roll, badcode set then cleared
    cmd_write(8'h02, 8'h07);
    check("bad_busy", {7'd0, busy}, 8'h00);
    read_chk("bad_status", 8'h00, 8'h12);
    i2c_rdata_used = 1'b1;
    step();
    i2c_rdata_used = 1'b0;
    read_chk("bad_clear", 8'h00, 8'h02);

    // Write to a non-CMD address is ignored
    cmd_write(8'h01, 8'h05);
    check("wr_other_busy", {7'd0, busy}, 8'h00);
    read_chk("unmapped_rd", 8'h07, 8'h00);

    // Third roll since reset
    btn_req = 7'b0000100;
    repeat (2) step();
    btn_req = 7'd0;
    step();
    check("d8_digits", {digit10, digit1}, 8'h07);
`ifdef DICE_SCHED_ROLLCNT_EN
    read_chk("rollcnt", 8'h03, 8'h03);
`else
    read_chk("rollcnt", 8'h03, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
